// File: rtl/mul_pkg.sv
// Shared definitions for the AVR multiply unit: mode encodings, FSM states
// and helpers that decode which operands are treated as signed.
package mul_pkg;

    localparam logic [2:0] MODE_MUL    = 3'b000;
    localparam logic [2:0] MODE_MULS   = 3'b001;
    localparam logic [2:0] MODE_MULSU  = 3'b010;
    localparam logic [2:0] MODE_FMUL   = 3'b100;
    localparam logic [2:0] MODE_FMULS  = 3'b101;
    localparam logic [2:0] MODE_FMULSU = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIN  = 2'b10,
        DONE = 2'b11
    } state_t;

    // Rd is signed for MULS/MULSU and their fractional forms.
    function automatic logic mode_rd_signed(input logic [2:0] mode);
        return (mode[1:0] == MODE_MULS[1:0]) || (mode[1:0] == MODE_MULSU[1:0]);
    endfunction

    // Rr is signed only for MULS/FMULS; the reserved code falls back to UxU.
    function automatic logic mode_rr_signed(input logic [2:0] mode);
        return (mode[1:0] == MODE_MULS[1:0]);
    endfunction

    function automatic logic mode_is_frac(input logic [2:0] mode);
        return mode[2];
    endfunction

endpackage

// File: rtl/mul_sign_cond.sv
// Operand conditioning: turns the requested mode and raw operands into
// unsigned magnitudes plus the sign of the final product.
module mul_sign_cond
    import mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] rd,
    input  logic [WIDTH-1:0] rr,
    output logic [WIDTH-1:0] rd_mag,
    output logic [WIDTH-1:0] rr_mag,
    output logic             neg
);

    logic rd_neg;
    logic rr_neg;

    // |-2^(WIDTH-1)| = 2^(WIDTH-1) still fits as an unsigned WIDTH-bit value.
    always_comb begin
        rd_neg = mode_rd_signed(mode) & rd[WIDTH-1];
        rr_neg = mode_rr_signed(mode) & rr[WIDTH-1];
        rd_mag = rd_neg ? (~rd + WIDTH'(1)) : rd;
        rr_mag = rr_neg ? (~rr + WIDTH'(1)) : rr;
        neg    = rd_neg ^ rr_neg;
    end

endmodule

// File: rtl/avr_mul_unit.sv
// Sequential shift-add multiplier for MUL/MULS/MULSU/FMUL/FMULS/FMULSU,
// one partial product per clock, with valid/ready on request and result.
module avr_mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_mode,
    input  logic [WIDTH-1:0] i_rd,
    input  logic [WIDTH-1:0] i_rr,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_r1,
    output logic [WIDTH-1:0] o_r0,
    output logic             o_c,
    output logic             o_z,
    output state_t           o_state
);

    // Handshake: a request transfers on an edge where i_valid && o_ready; a
    // result transfers on an edge where o_valid && i_ready. o_ready is high
    // only in IDLE and o_valid only in DONE, so the two never overlap.

    localparam int CNT_W = $clog2(WIDTH);
    localparam int PW    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic             neg;
    logic             frac;

    logic [WIDTH-1:0] rd_mag;
    logic [WIDTH-1:0] rr_mag;
    logic             neg_c;

    logic [PW-1:0]    partial;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    result;

    mul_sign_cond #(
        .WIDTH (WIDTH)
    ) u_sign_cond (
        .mode   (i_mode),
        .rd     (i_rd),
        .rr     (i_rr),
        .rd_mag (rd_mag),
        .rr_mag (rr_mag),
        .neg    (neg_c)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (i_valid) next_state = CALC;
            CALC:    if (cnt == CNT_LAST) next_state = FIN;
            FIN:     next_state = DONE;
            DONE:    if (i_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == IDLE);
        o_valid = (state == DONE);
        o_state = state;
    end

    // Product of magnitudes never exceeds 2*WIDTH bits, so acc cannot overflow.
    always_comb begin
        partial = {{WIDTH{1'b0}}, mcand} << cnt;
        prod    = neg ? (~acc + PW'(1)) : acc;
        result  = frac ? {prod[PW-2:0], 1'b0} : prod;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            frac   <= 1'b0;
            o_r1   <= '0;
            o_r0   <= '0;
            o_c    <= 1'b0;
            o_z    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        mcand  <= rd_mag;
                        mplier <= rr_mag;
                        neg    <= neg_c;
                        frac   <= mode_is_frac(i_mode);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    if (mplier[cnt]) begin
                        acc <= acc + partial;
                    end
                    cnt <= cnt + CNT_W'(1);
                end
                FIN: begin
                    // Carry reflects the unshifted product's MSB even in fractional mode.
                    o_c  <= prod[PW-1];
                    o_z  <= (result == '0);
                    o_r1 <= result[PW-1:WIDTH];
                    o_r0 <= result[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_avr_mul_unit.sv
// Scoreboard bench for avr_mul_unit: an 8-bit and a 16-bit instance driven
// with directed vectors whose expected results are worked out by hand.
module tb_avr_mul_unit;
    import mul_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- 8-bit instance ----------------
    logic        v8 = 1'b0;
    logic        rdy8;
    logic [2:0]  m8 = '0;
    logic [7:0]  rd8 = '0;
    logic [7:0]  rr8 = '0;
    logic        ov8;
    logic        ir8 = 1'b1;
    logic [7:0]  r1_8, r0_8;
    logic        c8, z8;
    state_t      st8;

    avr_mul_unit #(.WIDTH(8)) u_dut8 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (v8),
        .o_ready (rdy8),
        .i_mode  (m8),
        .i_rd    (rd8),
        .i_rr    (rr8),
        .o_valid (ov8),
        .i_ready (ir8),
        .o_r1    (r1_8),
        .o_r0    (r0_8),
        .o_c     (c8),
        .o_z     (z8),
        .o_state (st8)
    );

    // ---------------- 16-bit instance ----------------
    logic        v16 = 1'b0;
    logic        rdy16;
    logic [2:0]  m16 = '0;
    logic [15:0] rd16 = '0;
    logic [15:0] rr16 = '0;
    logic        ov16;
    logic        ir16 = 1'b1;
    logic [15:0] r1_16, r0_16;
    logic        c16, z16;
    state_t      st16;

    avr_mul_unit #(.WIDTH(16)) u_dut16 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (v16),
        .o_ready (rdy16),
        .i_mode  (m16),
        .i_rd    (rd16),
        .i_rr    (rr16),
        .o_valid (ov16),
        .i_ready (ir16),
        .o_r1    (r1_16),
        .o_r0    (r0_16),
        .o_c     (c16),
        .o_z     (z16),
        .o_state (st16)
    );

    // ---------------- scoreboard state ----------------
    logic [17:0] exp_q8[$];
    logic [33:0] exp_q16[$];
    int n_checks = 0;
    int n_pass = 0;
    time t_acc8 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst && ov8) begin
            if (exp_q8.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result8: got r1r0=0x%0h expected no result", {r1_8, r0_8});
            end else if (ir8) begin
                check("result8", 64'({r1_8, r0_8, c8, z8}), 64'(exp_q8.pop_front()));
            end else begin
                check("hold8", 64'({r1_8, r0_8, c8, z8}), 64'(exp_q8[0]));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ov16) begin
            if (exp_q16.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result16: got r1r0=0x%0h expected no result", {r1_16, r0_16});
            end else if (ir16) begin
                check("result16", 64'({r1_16, r0_16, c16, z16}), 64'(exp_q16.pop_front()));
            end else begin
                check("hold16", 64'({r1_16, r0_16, c16, z16}), 64'(exp_q16[0]));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send8(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                         input logic [17:0] e);
        int n = 0;
        @(negedge clk);
        v8 = 1'b1; m8 = m; rd8 = a; rr8 = b;
        while (!rdy8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rdy8) begin
            n_checks++;
            $display("FAIL accept_timeout8: got o_ready=0 expected 1 within 100 cycles");
            v8 = 1'b0;
            return;
        end
        exp_q8.push_back(e);
        @(posedge clk);
        t_acc8 = $time;
        #1 v8 = 1'b0;
    endtask

    task automatic send16(input logic [2:0] m, input logic [15:0] a, input logic [15:0] b,
                          input logic [33:0] e);
        int n = 0;
        @(negedge clk);
        v16 = 1'b1; m16 = m; rd16 = a; rr16 = b;
        while (!rdy16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rdy16) begin
            n_checks++;
            $display("FAIL accept_timeout16: got o_ready=0 expected 1 within 100 cycles");
            v16 = 1'b0;
            return;
        end
        exp_q16.push_back(e);
        @(posedge clk);
        #1 v16 = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q8.size() != 0 || exp_q16.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check({name, "_drained"}, 64'(exp_q8.size() + exp_q16.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int edges;
        time t0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready8", 64'(rdy8), 64'd1);
        check("reset_valid8", 64'(ov8), 64'd0);
        check("reset_out8", 64'({r1_8, r0_8, c8, z8}), 64'd0);
        check("reset_state8", 64'(st8), 64'(IDLE));
        check("reset_ready16", 64'(rdy16), 64'd1);
        @(negedge clk) rst = 1'b0;

        // Latency: edges counted including the accept edge itself.
        send8(MODE_FMUL, 8'h80, 8'h80, {16'h8000, 1'b0, 1'b0});
        edges = 1;
        while (!ov8 && edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("latency8", 64'(edges), 64'd10);

        // Back-to-back throughput with i_ready held high.
        send8(MODE_FMUL, 8'h80, 8'h00, {16'h0000, 1'b0, 1'b1});
        t0 = t_acc8;
        send8(MODE_FMUL, 8'hC0, 8'hC0, {16'h2000, 1'b1, 1'b0});
        check("throughput8", 64'((t_acc8 - t0) / 10), 64'd11);

        send8(MODE_FMULS,  8'h80, 8'h80, {16'h8000, 1'b0, 1'b0});
        send8(MODE_MULS,   8'h40, 8'hC0, {16'hF000, 1'b1, 1'b0});
        send8(MODE_MULSU,  8'hFF, 8'hFF, {16'hFF01, 1'b1, 1'b0});
        send8(MODE_MUL,    8'h01, 8'h01, {16'h0001, 1'b0, 1'b0});
        send8(3'b011,      8'hFF, 8'h02, {16'h01FE, 1'b0, 1'b0});
        send8(3'b111,      8'hFF, 8'h02, {16'h03FC, 1'b0, 1'b0});
        send8(MODE_MULS,   8'h7F, 8'h80, {16'hC080, 1'b1, 1'b0});
        send8(MODE_FMULSU, 8'h80, 8'hFF, {16'h0100, 1'b1, 1'b0});
        drain("directed8");

        // Backpressure, with stray requests while busy.
        ir8 = 1'b0;
        send8(MODE_FMULS, 8'hC0, 8'h40, {16'hE000, 1'b1, 1'b0});
        @(negedge clk);
        check("busy_ready8", 64'(rdy8), 64'd0);
        for (int i = 0; i < 6; i++) begin
            v8 = 1'($urandom_range(0, 1));
            m8 = 3'($urandom_range(0, 7));
            rd8 = 8'($urandom_range(0, 255));
            rr8 = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        v8 = 1'b0;
        edges = 0;
        while (!ov8 && edges < 50) begin
            @(negedge clk);
            edges++;
        end
        check("bp_valid_seen8", 64'(ov8), 64'd1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 ir8 = 1'b1;
        drain("backpressure8");
        @(negedge clk);
        check("retain_out8", 64'({r1_8, r0_8, c8, z8}), 64'({16'hE000, 1'b1, 1'b0}));
        check("retain_idle8", 64'({rdy8, ov8}), 64'b10);
        repeat (15) @(negedge clk);

        // Reset mid-CALC.
        send8(MODE_MUL, 8'h10, 8'h10, {16'h0100, 1'b0, 1'b0});
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        exp_q8.delete();
        #1;
        check("abort_ready8", 64'(rdy8), 64'd1);
        check("abort_valid8", 64'(ov8), 64'd0);
        check("abort_out8", 64'({r1_8, r0_8, c8, z8}), 64'd0);
        check("abort_state8", 64'(st8), 64'(IDLE));
        @(negedge clk) rst = 1'b0;
        repeat (15) @(negedge clk);
        send8(MODE_MUL, 8'h10, 8'h10, {16'h0100, 1'b0, 1'b0});
        drain("after_abort8");

        // 16-bit directed set.
        send16(MODE_MULS,   16'h8000, 16'h8000, {32'h4000_0000, 1'b0, 1'b0});
        send16(MODE_FMULS,  16'h8000, 16'h8000, {32'h8000_0000, 1'b0, 1'b0});
        send16(MODE_MULSU,  16'h8000, 16'hFFFF, {32'h8000_8000, 1'b1, 1'b0});
        send16(MODE_MUL,    16'hFFFF, 16'hFFFF, {32'hFFFE_0001, 1'b1, 1'b0});
        send16(MODE_FMUL,   16'hFFFF, 16'hFFFF, {32'hFFFC_0002, 1'b1, 1'b0});
        send16(MODE_MULS,   16'h1234, 16'h0000, {32'h0000_0000, 1'b0, 1'b1});
        send16(3'b011,      16'hFFFF, 16'h0002, {32'h0001_FFFE, 1'b0, 1'b0});
        send16(MODE_FMULSU, 16'hFFFF, 16'h8000, {32'hFFFF_0000, 1'b1, 1'b0});
        send16(MODE_MULS,   16'h7FFF, 16'h8000, {32'hC000_8000, 1'b1, 1'b0});
        send16(MODE_MUL,    16'h8000, 16'h0001, {32'h0000_8000, 1'b0, 1'b0});
        send16(MODE_FMUL,   16'h8000, 16'h8000, {32'h8000_0000, 1'b0, 1'b0});
        send16(MODE_MULSU,  16'h0003, 16'h8000, {32'h0001_8000, 1'b0, 1'b0});
        drain("directed16");

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000 time units");
        $fatal(1);
    end

endmodule
